// File: rtl/jtag_pkg.sv
// Shared constants and output-stage state encoding for the serial word receiver.
package jtag_pkg;

  localparam int WORD_WIDTH = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/word_receiver.sv
// Serial-to-parallel receiver: assembles MSB-first bits into WIDTH-bit words
// and holds each completed word in a one-entry output stage with valid/ready.
module word_receiver
  import jtag_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic                         in,
  input  logic                         clear,
  output logic [WIDTH-1:0]             out_word,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         overflow
);

  localparam int CW = $clog2(WIDTH+1);

  // Only WIDTH-1 bits are stored; the final bit comes straight from the input.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             overflow_q, overflow_d;
  out_state_e       state_q, state_d;

  logic [WIDTH-1:0] new_word;
  logic             complete;

  assign new_word = {shift_q, in};

  always_comb begin
    shift_d  = shift_q;
    count_d  = count_q;
    complete = 1'b0;
    if (clear) begin
      shift_d = '0;
      count_d = '0;
    end else if (enable) begin
      shift_d = new_word[WIDTH-2:0];
      if (count_q == CW'(WIDTH-1)) begin
        complete = 1'b1;
        count_d  = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    overflow_d = overflow_q;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          word_d  = new_word;
        end
      end
      FULL: begin
        if (complete) begin
          if (out_ready) word_d = new_word;
          else           overflow_d = 1'b1;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (clear) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      count_q    <= '0;
      word_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= EMPTY;
    end else begin
      shift_q    <= shift_d;
      count_q    <= count_d;
      word_q     <= word_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  assign out_word  = word_q;
  assign out_valid = (state_q == FULL);
  assign bit_count = count_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_word_receiver.sv
// Self-checking bench for word_receiver: directed scenarios plus random traffic,
// all compared against a bit-list reference model of the receiver.
module tb_word_receiver;

  localparam int W  = 32;
  localparam int CW = $clog2(W+1);

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          serialIn;
  logic          clear;
  logic [W-1:0]  outWord;
  logic          outValid;
  logic          outReady;
  logic [CW-1:0] bitCount;
  logic          overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state: bits received so far, and the output holding slot.
  int              mCount;
  longint unsigned mPartial;
  logic [W-1:0]    mWord;
  logic            mValid;
  logic            mOverflow;

  word_receiver #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in        (serialIn),
    .clear     (clear),
    .out_word  (outWord),
    .out_valid (outValid),
    .out_ready (outReady),
    .bit_count (bitCount),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic modelReset();
    mCount    = 0;
    mPartial  = 0;
    mWord     = '0;
    mValid    = 1'b0;
    mOverflow = 1'b0;
  endtask

  // One clock of the receiver's behaviour, stated from its rules directly.
  task automatic modelStep(input logic en, input logic din, input logic clr, input logic rdy);
    bit done = 0;
    longint unsigned finished = 0;
    if (clr) begin
      mCount    = 0;
      mPartial  = 0;
      mOverflow = 1'b0;
    end else if (en) begin
      mPartial = mPartial * 2 + longint'(din);
      mCount++;
      if (mCount == W) begin
        done     = 1;
        finished = mPartial;
        mCount   = 0;
        mPartial = 0;
      end
    end
    if (done) begin
      if (!mValid || rdy) begin
        mWord  = finished[W-1:0];
        mValid = 1'b1;
      end else begin
        mOverflow = 1'b1;
      end
    end else if (mValid && rdy) begin
      mValid = 1'b0;
    end
  endtask

  task automatic expectEq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".out_word"},  64'(outWord),  64'(mWord));
    expectEq({tag, ".out_valid"}, 64'(outValid), 64'(mValid));
    expectEq({tag, ".bit_count"}, 64'(bitCount), 64'(mCount));
    expectEq({tag, ".overflow"},  64'(overflow), 64'(mOverflow));
  endtask

  // Drive one cycle of inputs, clock it, advance the model and compare.
  task automatic applyStimulus(input logic en, input logic din, input logic clr,
                               input logic rdy, input string tag);
    enable   = en;
    serialIn = din;
    clear    = clr;
    outReady = rdy;
    @(posedge clk);
    modelStep(en, din, clr, rdy);
    #1;
    checkOutput(tag);
  endtask

  task automatic sendWord(input logic [W-1:0] w, input logic rdy, input logic rdyLast, input string tag);
    for (int i = W-1; i >= 0; i--)
      applyStimulus(1'b1, w[i], 1'b0, (i == 0) ? rdyLast : rdy, tag);
  endtask

  initial begin
    logic [W-1:0] wordA;
    logic [W-1:0] wordB;
    rst_n    = 1'b0;
    enable   = 1'b0;
    serialIn = 1'b0;
    clear    = 1'b0;
    outReady = 1'b0;
    modelReset();
    #2;
    checkOutput("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous 0xDEADBEEF
    sendWord(32'hDEADBEEF, 1'b0, 1'b0, "deadbeef");
    expectEq("deadbeef.word",  64'(outWord),  64'h DEADBEEF);
    expectEq("deadbeef.valid", 64'(outValid), 64'd1);
    expectEq("deadbeef.count", 64'(bitCount), 64'd0);
    expectEq("deadbeef.ovf",   64'(overflow), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "deadbeef.accept");

    // 10 ones, 5 idle cycles, 22 zeros
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "ones");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "idle");
      expectEq("idle.count", 64'(bitCount), 64'd10);
    end
    for (int i = 0; i < 22; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "zeros");
    expectEq("gap.word", 64'(outWord), 64'h FFC00000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "gap.accept");

    // Overflow: A unaccepted while B completes
    wordA = 32'h12345678;
    wordB = 32'hCAFEF00D;
    sendWord(wordA, 1'b0, 1'b0, "ovfA");
    sendWord(wordB, 1'b0, 1'b0, "ovfB");
    expectEq("ovf.word", 64'(outWord), 64'(wordA));
    expectEq("ovf.flag", 64'(overflow), 64'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "ovf.accept");
    expectEq("ovf.validAfterAccept", 64'(outValid), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, "ovf.clear");
    expectEq("ovf.cleared", 64'(overflow), 64'd0);

    // Ready arrives together with B's last bit
    sendWord(wordA, 1'b0, 1'b0, "sameA");
    sendWord(wordB, 1'b0, 1'b1, "sameB");
    expectEq("same.valid", 64'(outValid), 64'd1);
    expectEq("same.word",  64'(outWord),  64'(wordB));
    expectEq("same.ovf",   64'(overflow), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "same.accept");

    // Clear after 17 bits, then a clean word
    for (int i = 0; i < 17; i++) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, "partial17");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "clear17");
    expectEq("clear17.count", 64'(bitCount), 64'd0);
    sendWord(32'h0000FFFF, 1'b0, 1'b0, "afterClear");
    expectEq("afterClear.word", 64'(outWord), 64'h0000FFFF);

    // Clear on the would-be completing cycle while FULL: no word, no overflow
    for (int i = 0; i < W-1; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "preClear31");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, "clearOnLast");
    expectEq("clearOnLast.word", 64'(outWord), 64'h0000FFFF);
    expectEq("clearOnLast.ovf",  64'(overflow), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "clearOnLast.accept");

    // Asynchronous reset mid-word
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "pre-reset");
    sendWord(32'h0, 1'b0, 1'b0, "fillBeforeReset");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, "midword");
    enable = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("asyncReset");
    @(negedge clk);
    rst_n = 1'b1;
    sendWord(32'hA5C3_0F96, 1'b0, 1'b0, "postReset");
    expectEq("postReset.word", 64'(outWord), 64'hA5C30F96);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "postReset.accept");

    // Random traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 2) == 0), "random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
